// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit bus between N_REQ level-request drivers, with a hold limit.
// Latency: req -> gnt/owner/busy one cycle (registered); out is combinational from registered gnt and live din.
// No backpressure: requests are levels, unserved requests are not latched; ownership is capped at MAX_HOLD when others wait.
module bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   din,
    output logic [N_REQ-1:0]         gnt,
    output logic [2:0]               owner,
    output logic                     busy,
    output logic [WIDTH-1:0]         out
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HC_W  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    // Hold counter ceiling; with no hold limit the counter just pins at all-ones.
    localparam logic [HC_W-1:0]  HC_SAT  = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD) : '1;
    localparam logic [PTR_W:0]   N_REQ_W = (PTR_W + 1)'(N_REQ);
    localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(N_REQ - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [2:0]         owner_q, owner_d;
    logic               busy_q, busy_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [HC_W-1:0]    hold_q, hold_d;

    logic [N_REQ-1:0]   cand;
    logic [N_REQ-1:0]   rot;
    logic [PTR_W-1:0]   win_off;
    logic [PTR_W:0]     win_sum;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   win_nxt;
    logic [N_REQ-1:0]   win_onehot;
    logic               win_vld;
    logic               own_req;
    logic               take;
    logic [WIDTH-1:0]   out_mux;

    // Round-robin search: rotate candidates so ptr lands at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        cand    = (state_q == ST_OWNED) ? (req & ~gnt_q) : req;
        rot     = N_REQ'({cand, cand} >> ptr_q);
        win_vld = |rot;
        win_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                win_off = PTR_W'(k);
            end
        end
        win_sum = {1'b0, ptr_q} + {1'b0, win_off};
        if (win_sum >= N_REQ_W) begin
            win_sum = win_sum - N_REQ_W;
        end
        win_idx    = win_sum[PTR_W-1:0];
        win_nxt    = (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
        win_onehot = N_REQ'(1) << win_idx;
    end

    // Ownership decisions: grant from idle, hold/saturate, preempt at the hold limit, hand over, or release.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        take    = 1'b0;
        own_req = |(req & gnt_q);

        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    take = 1'b1;
                end
            end
            ST_OWNED: begin
                if (own_req) begin
                    if (win_vld && (MAX_HOLD != 0) && (hold_q == HC_SAT)) begin
                        take = 1'b1;
                    end else if (hold_q != HC_SAT) begin
                        hold_d = hold_q + 1'b1;
                    end
                end else if (win_vld) begin
                    take = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    owner_d = '0;
                    busy_d  = 1'b0;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                owner_d = '0;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
        endcase

        // A new owner always restarts the hold count and moves the pointer past itself.
        if (take) begin
            state_d = ST_OWNED;
            gnt_d   = win_onehot;
            owner_d = 3'(win_idx);
            busy_d  = 1'b1;
            ptr_d   = win_nxt;
            hold_d  = HC_W'(1);
        end
    end

    // State and registered outputs; reset drops any grant in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // AND-OR bus mux keyed by the one-hot grant; zero when nobody owns the bus.
    always_comb begin
        out_mux = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                out_mux = out_mux | din[i*WIDTH +: WIDTH];
            end
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = busy_q;
    assign out   = out_mux;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed scenarios plus randomized req/din/rst against a behavioural model.
// Latency: model updated at each rising edge, DUT outputs compared on the following falling edge.
// Inputs change only on falling edges, so the DUT and the model always see the same sampled values.
module tb_bus_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int MH  = 8;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   din;
    logic [N-1:0]     gnt;
    logic [2:0]       owner;
    logic             busy;
    logic [W-1:0]     out_w;

    int checks;
    int errors;

    // Reference model state: who owns the bus, where the next search starts, how long the owner has held.
    int m_busy;
    int m_owner;
    int m_ptr;
    int m_hold;

    bus_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .out   (out_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First requester in mask at or after start, wrapping; -1 when mask is empty.
    function automatic int pick(input int mask, input int start);
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (start + i) % N;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic give(input int w);
        m_busy  = 1;
        m_owner = w;
        m_ptr   = (w + 1) % N;
        m_hold  = 1;
    endtask

    task automatic model_edge();
        int r;
        int others;
        r = int'(req);
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
        end else if (m_busy == 0) begin
            if (r != 0) give(pick(r, m_ptr));
        end else begin
            others = r & ~(1 << m_owner);
            if (r[m_owner]) begin
                if (others != 0 && m_hold >= MH) give(pick(others, m_ptr));
                else if (m_hold < MH) m_hold++;
            end else if (others != 0) begin
                give(pick(others, m_ptr));
            end else begin
                m_busy = 0; m_hold = 0;
            end
        end
    endtask

    // One clock: model follows the edge, then every observable output is compared mid-cycle.
    task automatic tick();
        logic [N-1:0] exp_gnt;
        logic [W-1:0] exp_out;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        exp_gnt = (m_busy != 0) ? N'(1 << m_owner) : '0;
        exp_out = (m_busy != 0) ? din[m_owner*W +: W] : '0;
        check("gnt",  32'(gnt),   32'(exp_gnt));
        check("busy", 32'(busy),  32'(m_busy));
        check("out",  32'(out_w), 32'(exp_out));
        if (m_busy != 0) begin
            check("owner", 32'(owner),      32'(m_owner));
            check("hold",  32'(dut.hold_q), 32'(m_hold));
        end
    endtask

    task automatic run(input logic r, input logic [N-1:0] q, input int n);
        rst = r;
        req = q;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        checks = 0; errors = 0;
        m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
        rst = 1'b1; req = '0; din = '0;
        for (int i = 0; i < N; i++) din[i*W +: W] = 16'h1000 + 16'(i);
        @(negedge clk);

        // Reset held with all requests up: bus stays dead, then requester 0 wins first.
        run(1'b1, 4'b1111, 2);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_out", 32'(out_w), 32'h0);
        run(1'b0, 4'b1111, 1);
        check("first_gnt", 32'(gnt), 32'h1);
        run(1'b0, 4'b0000, 2);

        // Single requester 2 with a known data word, then release.
        din[2*W +: W] = 16'hBEEF;
        run(1'b0, 4'b0100, 1);
        check("beef_gnt", 32'(gnt), 32'h4);
        check("beef_own", 32'(owner), 32'd2);
        check("beef_out", 32'(out_w), 32'hBEEF);
        run(1'b0, 4'b0000, 1);
        check("drop_busy", 32'(busy), 32'h0);
        check("drop_out", 32'(out_w), 32'h0);

        // Two contenders: alternate every MAX_HOLD cycles, never idle.
        run(1'b0, 4'b1010, 40);

        // Lone requester keeps the bus and the hold count pins at the limit.
        run(1'b1, 4'b0000, 1);
        run(1'b0, 4'b0001, 20);
        check("lone_gnt", 32'(gnt), 32'h1);
        check("lone_hold", 32'(dut.hold_q), 32'(MH));

        // Owner 1 drops while 3 is waiting: direct handover.
        run(1'b1, 4'b0000, 1);
        run(1'b0, 4'b0010, 3);
        run(1'b0, 4'b1000, 1);
        check("hand_gnt", 32'(gnt), 32'h8);
        check("hand_hold", 32'(dut.hold_q), 32'h1);

        // Reset mid-grant clears the pointer as well.
        run(1'b1, 4'b0000, 1);
        run(1'b0, 4'b0100, 3);
        run(1'b1, 4'b0100, 1);
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        run(1'b0, 4'b1111, 1);
        check("post_rst_gnt", 32'(gnt), 32'h1);

        // Random traffic with occasional resets and changing data.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(63) == 0);
            if ($urandom_range(3) == 0) req = N'($urandom);
            for (int i = 0; i < N; i++) din[i*W +: W] = 16'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
